byte_issue: RTL and testbench

BYTE_ISSUE -- requirements
Module: byte_issue

---
 rtl/byte_issue_if.sv | 47 ++++
 rtl/byte_issue.sv | 132 +++++++++++++
 tb/tb_byte_issue.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/byte_issue_if.sv
// byte_issue_if: decoder handshake, register-file read/write-back and byte-pipe issue signals.
// The decoder/bench drives through master; byte_issue connects through slave.
interface byte_issue_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:10]  in_op_code;
  logic [2:0]   in_format;
  logic [0:17]  in_imm;
  logic [0:6]   in_rt;
  logic [0:6]   in_ra;
  logic [0:6]   in_rb;
  logic         in_ra_used;
  logic         in_rb_used;
  logic         in_reg_write;
  logic [0:6]   rf_addr_a;
  logic [0:6]   rf_addr_b;
  logic [0:127] rf_data_a;
  logic [0:127] rf_data_b;
  logic [0:127] wb_data;
  logic [0:6]   wb_reg_addr;
  logic         wb_enable_reg_write;
  logic         flush;
  logic [0:10]  op_code;
  logic [2:0]   instr_format;
  logic [0:6]   dest_reg_addr;
  logic [0:127] src_reg_a;
  logic [0:127] src_reg_b;
  logic [0:17]  imm_value;
  logic         enable_reg_write;
  logic [15:0]  stall_count;

  modport slave (
    input  in_valid, in_op_code, in_format, in_imm, in_rt, in_ra, in_rb,
           in_ra_used, in_rb_used, in_reg_write, rf_data_a, rf_data_b,
           wb_data, wb_reg_addr, wb_enable_reg_write, flush,
    output in_ready, rf_addr_a, rf_addr_b, op_code, instr_format, dest_reg_addr,
           src_reg_a, src_reg_b, imm_value, enable_reg_write, stall_count
  );

  modport master (
    output in_valid, in_op_code, in_format, in_imm, in_rt, in_ra, in_rb,
           in_ra_used, in_rb_used, in_reg_write, rf_data_a, rf_data_b,
           wb_data, wb_reg_addr, wb_enable_reg_write, flush,
    input  in_ready, rf_addr_a, rf_addr_b, op_code, instr_format, dest_reg_addr,
           src_reg_a, src_reg_b, imm_value, enable_reg_write, stall_count
  );
endinterface

// File: rtl/byte_issue.sv
// byte_issue: single-entry issue stage for the byte pipe with a 3-deep write scoreboard.
// Define BYTE_ISSUE_WB_BYPASS_EN to forward write-back data and drop sb[2] from the hazard check.
module byte_issue (
  input logic        clock,
  input logic        reset,
  byte_issue_if.slave bus
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] READY = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

`ifdef BYTE_ISSUE_WB_BYPASS_EN
  localparam logic [2:0] SB_CHECK = 3'b011;
`else
  localparam logic [2:0] SB_CHECK = 3'b111;
`endif

  typedef struct packed {
    logic [0:10] op;
    logic [2:0]  fmt;
    logic [0:17] imm;
    logic [0:6]  rt;
    logic [0:6]  ra;
    logic [0:6]  rb;
    logic        ra_used;
    logic        rb_used;
    logic        rw;
  } instr_t;

  function automatic logic uses(input instr_t i, input logic [0:6] rt);
    return (i.ra_used && (i.ra == rt)) || (i.rb_used && (i.rb == rt));
  endfunction

  function automatic logic hazard(input instr_t i, input logic [2:0] vld,
                                  input logic [0:6] rt0, input logic [0:6] rt1,
                                  input logic [0:6] rt2);
    logic [2:0] v;
    v = vld & SB_CHECK;
    return (v[0] && uses(i, rt0)) || (v[1] && uses(i, rt1)) || (v[2] && uses(i, rt2));
  endfunction

  logic [1:0]   state_q, state_d;
  instr_t       hold_q, hold_d, in_instr;
  logic [2:0]   sb_vld_q, sb_vld_d;
  logic [0:6]   sb_rt_q [3];
  logic [0:6]   sb_rt_d [3];
  logic [15:0]  stall_q, stall_d;
  logic [0:10]  op_q;
  logic [2:0]   fmt_q;
  logic [0:6]   dest_q;
  logic [0:127] src_a_q, src_b_q;
  logic [0:17]  imm_q;
  logic         rw_q;
  logic [0:127] src_a, src_b;
  logic         hazard_now, issue, ready, accept;

  assign in_instr = {bus.in_op_code, bus.in_format, bus.in_imm, bus.in_rt, bus.in_ra,
                     bus.in_rb, bus.in_ra_used, bus.in_rb_used, bus.in_reg_write};

  assign hazard_now = hazard(hold_q, sb_vld_q, sb_rt_q[0], sb_rt_q[1], sb_rt_q[2]);
  assign issue      = (state_q == READY) && !bus.flush && !hazard_now;
  assign ready      = !reset && !bus.flush && ((state_q == EMPTY) || issue);
  assign accept     = bus.in_valid && ready;

  always_comb begin
    sb_vld_d   = {sb_vld_q[1:0], issue & hold_q.rw};
    sb_rt_d[0] = hold_q.rt;
    sb_rt_d[1] = sb_rt_q[0];
    sb_rt_d[2] = sb_rt_q[1];
    hold_d     = accept ? in_instr : hold_q;
    // Next state is judged against the scoreboard as it will look after this edge,
    // so a new or stalled entry lands in READY exactly when it can issue.
    state_d = EMPTY;
    if (!bus.flush && (accept || ((state_q != EMPTY) && !issue)))
      state_d = hazard(hold_d, sb_vld_d, sb_rt_d[0], sb_rt_d[1], sb_rt_d[2]) ? STALL : READY;
    stall_d = ((state_q == STALL) && (stall_q != '1)) ? stall_q + 16'd1 : stall_q;
  end

`ifdef BYTE_ISSUE_WB_BYPASS_EN
  assign src_a = (hold_q.ra_used && bus.wb_enable_reg_write && (bus.wb_reg_addr == hold_q.ra))
                 ? bus.wb_data : bus.rf_data_a;
  assign src_b = (hold_q.rb_used && bus.wb_enable_reg_write && (bus.wb_reg_addr == hold_q.rb))
                 ? bus.wb_data : bus.rf_data_b;
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_data, bus.wb_reg_addr, bus.wb_enable_reg_write};
  assign src_a = bus.rf_data_a;
  assign src_b = bus.rf_data_b;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= EMPTY;
      hold_q   <= '0;
      sb_vld_q <= '0;
      sb_rt_q  <= '{default: '0};
      stall_q  <= '0;
      op_q     <= '0;
      fmt_q    <= '0;
      dest_q   <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      imm_q    <= '0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      sb_vld_q <= sb_vld_d;
      sb_rt_q  <= sb_rt_d;
      stall_q  <= stall_d;
      op_q     <= issue ? hold_q.op  : '0;
      fmt_q    <= issue ? hold_q.fmt : '0;
      dest_q   <= issue ? hold_q.rt  : '0;
      src_a_q  <= issue ? src_a      : '0;
      src_b_q  <= issue ? src_b      : '0;
      imm_q    <= issue ? hold_q.imm : '0;
      rw_q     <= issue && hold_q.rw;
    end
  end

  assign bus.in_ready         = ready;
  assign bus.rf_addr_a        = hold_q.ra;
  assign bus.rf_addr_b        = hold_q.rb;
  assign bus.op_code          = op_q;
  assign bus.instr_format     = fmt_q;
  assign bus.dest_reg_addr    = dest_q;
  assign bus.src_reg_a        = src_a_q;
  assign bus.src_reg_b        = src_b_q;
  assign bus.imm_value        = imm_q;
  assign bus.enable_reg_write = rw_q;
  assign bus.stall_count      = stall_q;
endmodule

// File: tb/tb_byte_issue.sv
// tb_byte_issue: directed cycle-by-cycle vectors for byte_issue with a small register-file model.
// Expected values follow BYTE_ISSUE_WB_BYPASS_EN when it is defined.
module tb_byte_issue;
`ifdef BYTE_ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  byte_issue_if bus ();
  byte_issue dut (.clock(clock), .reset(reset), .bus(bus));

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Register file: reg n reads back as rfval(n) unless overwritten by the latest write-back.
  function automatic logic [0:127] rfval(input logic [0:6] a);
    return {16{1'b1, a}};
  endfunction

  logic         ov_vld;
  logic [0:6]   ov_addr;
  logic [0:127] ov_data;
  always @(posedge clock) begin
    if (reset) ov_vld <= 1'b0;
    else if (bus.wb_enable_reg_write) begin
      ov_vld  <= 1'b1;
      ov_addr <= bus.wb_reg_addr;
      ov_data <= bus.wb_data;
    end
  end
  assign bus.rf_data_a = (ov_vld && ov_addr == bus.rf_addr_a) ? ov_data : rfval(bus.rf_addr_a);
  assign bus.rf_data_b = (ov_vld && ov_addr == bus.rf_addr_b) ? ov_data : rfval(bus.rf_addr_b);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ef(input logic [0:10] op, input logic [0:6] rt, input logic rw);
    return {88'd0, op, op[8:10], rt, op, rt, rw};
  endfunction

  task automatic chk_out(input string tag, input logic [0:10] op, input logic [0:6] rt,
                         input logic rw, input logic [0:127] sa, input logic [0:127] sb);
    chk({tag, "_fields"}, {88'd0, bus.op_code, bus.instr_format, bus.dest_reg_addr,
                           bus.imm_value, bus.enable_reg_write}, ef(op, rt, rw));
    chk({tag, "_srca"}, bus.src_reg_a, sa);
    chk({tag, "_srcb"}, bus.src_reg_b, sb);
  endtask

  task automatic chk_nop(input string tag);
    chk_out(tag, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic drive(input logic v, input logic [0:10] op, input logic [0:6] rt,
                       input logic [0:6] ra, input logic [0:6] rb,
                       input logic rau, input logic rbu, input logic rw);
    bus.in_valid     = v;
    bus.in_op_code   = op;
    bus.in_format    = op[8:10];
    bus.in_imm       = {op, rt};
    bus.in_rt        = rt;
    bus.in_ra        = ra;
    bus.in_rb        = rb;
    bus.in_ra_used   = rau;
    bus.in_rb_used   = rbu;
    bus.in_reg_write = rw;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [0:127] w;
    int unsigned  cyc;
    int unsigned  exp_stall;
    w = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    exp_stall = 0;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.wb_enable_reg_write = 1'b0;
    bus.wb_reg_addr = '0;
    bus.wb_data = '0;
    idle();

    // Reset and idle
    repeat (2) tick();
    chk("rst_ready", bus.in_ready, 0);
    chk_nop("rst_out");
    chk("rst_stall", bus.stall_count, 0);
    reset = 1'b0;
    #1 chk("post_rst_ready", bus.in_ready, 1);
    tick();
    chk_nop("idle_out");
    chk("idle_ready", bus.in_ready, 1);

    // Four independent instructions, one per cycle
    drive(1'b1, 11'h101, 7'd1, 7'd10, 7'd10, 1'b1, 1'b1, 1'b1);
    #1 chk("s1_ready", bus.in_ready, 1);
    tick();
    drive(1'b1, 11'h102, 7'd2, 7'd10, 7'd10, 1'b1, 1'b1, 1'b1);
    #1 chk("s2_ready", bus.in_ready, 1);
    tick();
    chk_out("s_i1", 11'h101, 7'd1, 1'b1, rfval(7'd10), rfval(7'd10));
    drive(1'b1, 11'h103, 7'd3, 7'd10, 7'd10, 1'b1, 1'b1, 1'b1);
    #1 chk("s3_ready", bus.in_ready, 1);
    tick();
    chk_out("s_i2", 11'h102, 7'd2, 1'b1, rfval(7'd10), rfval(7'd10));
    drive(1'b1, 11'h104, 7'd4, 7'd10, 7'd10, 1'b1, 1'b1, 1'b1);
    #1 chk("s4_ready", bus.in_ready, 1);
    tick();
    chk_out("s_i3", 11'h103, 7'd3, 1'b1, rfval(7'd10), rfval(7'd10));
    idle();
    tick();
    chk_out("s_i4", 11'h104, 7'd4, 1'b1, rfval(7'd10), rfval(7'd10));
    tick();
    chk_nop("s_after");
    chk("s_stall", bus.stall_count, exp_stall);

    // Unused rb matching a pending rt does not stall
    drive(1'b1, 11'h111, 7'd9, 7'd1, 7'd2, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 11'h112, 7'd11, 7'd3, 7'd9, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("nb_x", 11'h111, 7'd9, 1'b1, rfval(7'd1), rfval(7'd2));
    idle();
    #1 chk("nb_ready", bus.in_ready, 1);
    tick();
    chk_out("nb_y", 11'h112, 7'd11, 1'b1, rfval(7'd3), rfval(7'd9));
    chk("nb_stall", bus.stall_count, exp_stall);

    // cntb (rt=5) then dependent avgb (ra=5, rb=6)
    drive(1'b1, 11'h0A1, 7'd5, 7'd1, 7'd2, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 11'h0A2, 7'd7, 7'd5, 7'd6, 1'b1, 1'b1, 1'b1);
    #1 chk("avg_accept", bus.in_ready, 1);
    tick();
    chk_out("cntb", 11'h0A1, 7'd5, 1'b1, rfval(7'd1), rfval(7'd2));
    idle();
    #1 chk("avg_stall1", bus.in_ready, 0);
    chk("avg_rfaddr", {bus.rf_addr_a, bus.rf_addr_b}, {7'd5, 7'd6});
    tick();
    chk_nop("avg_c3");
    chk("avg_stall2", bus.in_ready, 0);
    bus.wb_enable_reg_write = 1'b1;
    bus.wb_reg_addr = 7'd5;
    bus.wb_data = w;
    tick();
    chk("avg_c4_ready", bus.in_ready, BYP ? 1 : 0);
    tick();
    bus.wb_enable_reg_write = 1'b0;
    chk_out("avg_c5", BYP ? 11'h0A2 : 11'h0, BYP ? 7'd7 : 7'd0, BYP,
            BYP ? w : '0, BYP ? rfval(7'd6) : '0);
    tick();
    chk_out("avg_c6", BYP ? 11'h0 : 11'h0A2, BYP ? 7'd0 : 7'd7, !BYP,
            BYP ? '0 : w, BYP ? '0 : rfval(7'd6));
    exp_stall += BYP ? 2 : 3;
    chk("avg_stall_cnt", bus.stall_count, exp_stall);

    // rt=0 is tracked; flush while stalled; older entry still drains
    drive(1'b1, 11'h0B1, 7'd0, 7'd1, 7'd2, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 11'h0B2, 7'd12, 7'd0, 7'd3, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("fl_p", 11'h0B1, 7'd0, 1'b1, rfval(7'd1), rfval(7'd2));
    idle();
    #1 chk("fl_r0_stall", bus.in_ready, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_nop("fl_out");
    drive(1'b1, 11'h0B3, 7'd13, 7'd0, 7'd3, 1'b1, 1'b1, 1'b1);
    #1 chk("fl_empty", bus.in_ready, 1);
    tick();
    chk_nop("fl_no_issue");
    idle();
    #1 chk("fl_drain_ready", bus.in_ready, BYP ? 1 : 0);
    tick();
    chk_out("fl_c5", BYP ? 11'h0B3 : 11'h0, BYP ? 7'd13 : 7'd0, BYP,
            BYP ? rfval(7'd0) : '0, BYP ? rfval(7'd3) : '0);
    tick();
    chk_out("fl_c6", BYP ? 11'h0 : 11'h0B3, BYP ? 7'd0 : 7'd13, !BYP,
            BYP ? '0 : rfval(7'd0), BYP ? '0 : rfval(7'd3));
    exp_stall += BYP ? 1 : 2;
    chk("fl_stall_cnt", bus.stall_count, exp_stall);

    // Reset mid-stall discards the held instruction
    drive(1'b1, 11'h0C1, 7'd20, 7'd1, 7'd2, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 11'h0C2, 7'd21, 7'd20, 7'd20, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("rs_s", 11'h0C1, 7'd20, 1'b1, rfval(7'd1), rfval(7'd2));
    idle();
    #1 chk("rs_stalled", bus.in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_stall = 0;
    chk_nop("rs_out");
    chk("rs_stall_cnt", bus.stall_count, exp_stall);
    #1 chk("rs_ready", bus.in_ready, 1);
    tick();
    chk_nop("rs_out2");
    tick();
    chk_nop("rs_out3");

    // Self-dependent stream keeps stalling until the counter saturates
    drive(1'b1, 11'h0D1, 7'd30, 7'd30, 7'd30, 1'b1, 1'b1, 1'b1);
    cyc = 0;
    while (bus.stall_count != 16'hFFFF && cyc < 100000) begin
      tick();
      cyc++;
    end
    chk("sat_reach", bus.stall_count, 16'hFFFF);
    repeat (8) tick();
    chk("sat_hold", bus.stall_count, 16'hFFFF);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
